// File: rtl/jpeg_block_axil_driver.sv
// rtl/jpeg_block_axil_driver.sv - AXI4-Lite master feeding one 8x8 block through the compression register block
//
// Collects BLOCK_WORDS input words from the s_* stream and writes each one to IN_BASE+cnt. It then
// writes START_ADDR<=1 and polls DONE_ADDR until it reads 1. It clears START and DONE, reads
// OUT_BASE+cnt back word by word, and emits each result on the m_* stream.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   s_data/s_valid/s_ready  input word stream (accepted only in LOAD)
//   m_data/m_valid/m_ready  result word stream (m_valid held until m_ready)
//   busy                    high whenever the FSM is not IDLE
//   err                     sticky: any non-OKAY BRESP/RRESP, or poll timeout
//   M_AXI_AW*/W*/B*         AXI4-Lite write channels (master side)
//   M_AXI_AR*/R*            AXI4-Lite read channels (master side)
//
// Build option: define POLL_TIMEOUT_EN to bound the done polling to TIMEOUT_CYCLES cycles.
module jpeg_block_axil_driver #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 8,
    parameter int                    BLOCK_WORDS    = 64,
    parameter logic [ADDR_WIDTH-1:0] IN_BASE        = 8'h00,
    parameter logic [ADDR_WIDTH-1:0] OUT_BASE       = 8'h40,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR     = 8'h81,
    parameter logic [ADDR_WIDTH-1:0] DONE_ADDR      = 8'h89,
    parameter int                    POLL_GAP       = 4,
    parameter int                    TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic                  M_AXI_AWVALID,
    input  logic                  M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0] M_AXI_WDATA,
    output logic                  M_AXI_WVALID,
    input  logic                  M_AXI_WREADY,
    input  logic [1:0]            M_AXI_BRESP,
    input  logic                  M_AXI_BVALID,
    output logic                  M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic                  M_AXI_ARVALID,
    input  logic                  M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]            M_AXI_RRESP,
    input  logic                  M_AXI_RVALID,
    output logic                  M_AXI_RREADY
);

    localparam int CNT_W = $clog2(BLOCK_WORDS);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_WR, S_START, S_POLL, S_GAP, S_CLR_S, S_CLR_D, S_FETCH, S_EMIT
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_word;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [7:0]            r_gap;
    logic                  r_err;
    // High from launching a transaction until its B or R handshake; guarantees one outstanding txn.
    logic                  r_issued;

    logic                  w_b_done;
    logic                  w_r_done;
    logic                  w_wr_state;
    logic                  w_rd_state;
    logic                  w_cnt_last;
    logic                  w_gap_done;
    logic                  w_timeout;
    logic                  w_tmo_fire;
    logic [ADDR_WIDTH-1:0] w_cnt_ext;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [ADDR_WIDTH-1:0] w_rd_addr;

    assign w_b_done   = M_AXI_BVALID & M_AXI_BREADY;
    assign w_r_done   = M_AXI_RVALID & M_AXI_RREADY;
    assign w_wr_state = (r_state == S_WR) || (r_state == S_START) ||
                        (r_state == S_CLR_S) || (r_state == S_CLR_D);
    assign w_rd_state = (r_state == S_POLL) || (r_state == S_FETCH);
    assign w_cnt_last = (r_cnt == CNT_W'(BLOCK_WORDS - 1));
    assign w_gap_done = (r_gap == 8'(POLL_GAP - 1));
    assign w_cnt_ext  = ADDR_WIDTH'(r_cnt);

`ifdef POLL_TIMEOUT_EN
    logic [15:0] r_tmo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo <= '0;
        end else if (r_state == S_START) begin
            r_tmo <= '0;
        end else if ((r_state == S_POLL || r_state == S_GAP) && (r_tmo != 16'hFFFF)) begin
            r_tmo <= r_tmo + 16'd1;
        end
    end

    assign w_timeout = (r_tmo >= 16'(TIMEOUT_CYCLES));
`else
    assign w_timeout = 1'b0;
`endif

    // The timeout only acts when no read is outstanding, so a poll read is never abandoned.
    assign w_tmo_fire = w_timeout && ((r_state == S_GAP) || (r_state == S_POLL && w_r_done));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_wr_addr = '0;
        w_wr_data = '0;
        w_rd_addr = '0;
        case (r_state)
            S_IDLE:  if (s_valid) w_next = S_LOAD;
            S_LOAD:  if (s_valid) w_next = S_WR;
            S_WR: begin
                w_wr_addr = IN_BASE + w_cnt_ext;
                w_wr_data = r_word;
                if (w_b_done) w_next = w_cnt_last ? S_START : S_LOAD;
            end
            S_START: begin
                w_wr_addr = START_ADDR;
                w_wr_data = DATA_WIDTH'(1);
                if (w_b_done) w_next = S_POLL;
            end
            S_POLL: begin
                w_rd_addr = DONE_ADDR;
                if (w_r_done) begin
                    w_next = ((M_AXI_RDATA == DATA_WIDTH'(1)) || w_tmo_fire) ? S_CLR_S : S_GAP;
                end
            end
            S_GAP: begin
                if (w_tmo_fire)      w_next = S_CLR_S;
                else if (w_gap_done) w_next = S_POLL;
            end
            S_CLR_S: begin
                w_wr_addr = START_ADDR;
                if (w_b_done) w_next = S_CLR_D;
            end
            S_CLR_D: begin
                w_wr_addr = DONE_ADDR;
                if (w_b_done) w_next = S_FETCH;
            end
            S_FETCH: begin
                w_rd_addr = OUT_BASE + w_cnt_ext;
                if (w_r_done) w_next = S_EMIT;
            end
            S_EMIT:  if (m_ready) w_next = w_cnt_last ? S_IDLE : S_FETCH;
            default: w_next = S_IDLE;
        endcase
    end

    // AXI channel registers. Address and data stay put until the response handshake because the
    // slave may sample them after its READY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            M_AXI_AWADDR  <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            r_issued      <= 1'b0;
        end else if (w_wr_state && !r_issued) begin
            M_AXI_AWADDR  <= w_wr_addr;
            M_AXI_WDATA   <= w_wr_data;
            M_AXI_AWVALID <= 1'b1;
            M_AXI_WVALID  <= 1'b1;
            M_AXI_BREADY  <= 1'b1;
            r_issued      <= 1'b1;
        end else if (w_rd_state && !r_issued) begin
            M_AXI_ARADDR  <= w_rd_addr;
            M_AXI_ARVALID <= 1'b1;
            M_AXI_RREADY  <= 1'b1;
            r_issued      <= 1'b1;
        end else begin
            if (M_AXI_AWVALID && M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
            if (M_AXI_WVALID && M_AXI_WREADY)   M_AXI_WVALID  <= 1'b0;
            if (M_AXI_ARVALID && M_AXI_ARREADY) M_AXI_ARVALID <= 1'b0;
            if (w_b_done) begin
                M_AXI_BREADY <= 1'b0;
                r_issued     <= 1'b0;
            end
            if (w_r_done) begin
                M_AXI_RREADY <= 1'b0;
                r_issued     <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_word  <= '0;
            r_rdata <= '0;
            r_gap   <= '0;
            r_err   <= 1'b0;
        end else begin
            if (r_state == S_LOAD && s_valid) r_word <= s_data;
            if ((r_state == S_WR && w_b_done) || (r_state == S_EMIT && m_ready)) begin
                r_cnt <= w_cnt_last ? '0 : r_cnt + 1'b1;
            end
            if (r_state == S_FETCH && w_r_done) r_rdata <= M_AXI_RDATA;
            r_gap <= (r_state == S_GAP) ? r_gap + 8'd1 : 8'd0;
            if ((w_b_done && M_AXI_BRESP != 2'b00) || (w_r_done && M_AXI_RRESP != 2'b00) ||
                w_tmo_fire) begin
                r_err <= 1'b1;
            end
        end
    end

    assign s_ready = (r_state == S_LOAD);
    assign m_valid = (r_state == S_EMIT);
    assign m_data  = r_rdata;
    assign busy    = (r_state != S_IDLE);
    assign err     = r_err;

endmodule

// File: tb/tb_jpeg_block_axil_driver.sv
// tb/tb_jpeg_block_axil_driver.sv - directed self-checking bench for jpeg_block_axil_driver
module tb_jpeg_block_axil_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        busy;
    logic        err;
    logic [7:0]  M_AXI_AWADDR;
    logic        M_AXI_AWVALID;
    logic        M_AXI_AWREADY;
    logic [31:0] M_AXI_WDATA;
    logic        M_AXI_WVALID;
    logic        M_AXI_WREADY;
    logic [1:0]  M_AXI_BRESP;
    logic        M_AXI_BVALID;
    logic        M_AXI_BREADY;
    logic [7:0]  M_AXI_ARADDR;
    logic        M_AXI_ARVALID;
    logic        M_AXI_ARREADY;
    logic [31:0] M_AXI_RDATA;
    logic [1:0]  M_AXI_RRESP;
    logic        M_AXI_RVALID;
    logic        M_AXI_RREADY;

    always #5 clk = ~clk;

    jpeg_block_axil_driver #(.POLL_GAP(4), .TIMEOUT_CYCLES(200)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .busy(busy), .err(err),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
        .M_AXI_RREADY(M_AXI_RREADY)
    );

    int errors = 0;
    int checks = 0;

    // Slave model state and transaction log
    logic [31:0] mem [0:255];
    logic [7:0]  wa [0:255];
    logic [31:0] wd [0:255];
    logic [7:0]  ra [0:255];
    logic [7:0]  cap_awaddr, cap_araddr;
    logic [31:0] cap_wdata;
    int ws = 0, rs = 0, wr_n = 0, rd_n = 0, viol = 0, cyc = 0;
    int poll_cnt = 0, done_after = 1, bad_wr_idx = -1;
    int last_poll = -1, min_gap = 1000, start_cyc = 0, err_cyc = -1;
    logic abort = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wr_n = 0; rd_n = 0; last_poll = -1; min_gap = 1000; err_cyc = -1;
    endtask

    // AXI-Lite slave: decisions made on the falling edge, seen by the DUT on the next rising edge.
    initial begin
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
        M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RDATA = 0; M_AXI_RRESP = 0;
        for (int i = 0; i < 256; i++) mem[i] = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
                M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RDATA = 0; M_AXI_RRESP = 0;
                ws = 0; rs = 0;
            end else begin
                if (err && err_cyc < 0) err_cyc = cyc;
                if (M_AXI_ARVALID && (ws != 0 || M_AXI_AWVALID)) viol++;
                if ((M_AXI_AWVALID || M_AXI_WVALID) && rs != 0) viol++;
                case (ws)
                    0: if (M_AXI_AWVALID && M_AXI_WVALID) begin
                        M_AXI_AWREADY = 1; M_AXI_WREADY = 1;
                        cap_awaddr = M_AXI_AWADDR; cap_wdata = M_AXI_WDATA; ws = 1;
                    end else if (M_AXI_AWVALID || M_AXI_WVALID) viol++;
                    1: begin
                        M_AXI_AWREADY = 0; M_AXI_WREADY = 0;
                        if (M_AXI_AWVALID || M_AXI_WVALID) viol++;
                        ws = 2;
                    end
                    2: begin
                        if (M_AXI_AWADDR !== cap_awaddr || M_AXI_WDATA !== cap_wdata || !M_AXI_BREADY) viol++;
                        M_AXI_BVALID = 1;
                        M_AXI_BRESP = (wr_n == bad_wr_idx) ? 2'b10 : 2'b00;
                        ws = 3;
                    end
                    default: begin
                        M_AXI_BVALID = 0; M_AXI_BRESP = 0;
                        wa[wr_n] = cap_awaddr; wd[wr_n] = cap_wdata; wr_n++;
                        mem[cap_awaddr] = cap_wdata;
                        if (cap_awaddr == 8'h81 && cap_wdata == 32'd1) begin
                            for (int i = 0; i < 64; i++) mem[8'h40 + i] = mem[i] + 32'd1;
                            poll_cnt = 0;
                            start_cyc = cyc;
                        end
                        ws = 0;
                    end
                endcase
                case (rs)
                    0: if (M_AXI_ARVALID) begin
                        M_AXI_ARREADY = 1; cap_araddr = M_AXI_ARADDR;
                        ra[rd_n] = M_AXI_ARADDR; rd_n++;
                        if (M_AXI_ARADDR == 8'h89 && last_poll >= 0 && (cyc - last_poll - 1) < min_gap)
                            min_gap = cyc - last_poll - 1;
                        rs = 1;
                    end
                    1: begin
                        M_AXI_ARREADY = 0;
                        if (M_AXI_ARVALID) viol++;
                        rs = 2;
                    end
                    2: begin
                        if (M_AXI_ARADDR !== cap_araddr || !M_AXI_RREADY) viol++;
                        M_AXI_RVALID = 1; M_AXI_RRESP = 0;
                        if (cap_araddr == 8'h89) begin
                            poll_cnt++;
                            M_AXI_RDATA = (done_after != 0 && poll_cnt >= done_after) ? 32'd1 : 32'd0;
                            last_poll = cyc;
                        end else begin
                            M_AXI_RDATA = mem[cap_araddr];
                        end
                        rs = 3;
                    end
                    default: begin
                        M_AXI_RVALID = 0; M_AXI_RDATA = 0; rs = 0;
                    end
                endcase
            end
        end
    end

    task automatic src(input int base, output int sent);
        sent = 0;
        for (int i = 0; i < 64; i++) begin
            int  b;
            logic acc;
            b = 0; acc = 0;
            s_data = 32'(base + i); s_valid = 1;
            while (!acc && !abort && b < 3000) begin
                acc = s_ready;
                @(negedge clk);
                b++;
            end
            if (!acc) break;
            sent++;
        end
        s_valid = 0;
    endtask

    task automatic snk(input int base, input int stall_idx, output int got, output int bad, output int stall_bad);
        int   b;
        logic stalled;
        logic [31:0] hold;
        got = 0; bad = 0; stall_bad = 0; b = 0; stalled = 0;
        m_ready = 1;
        while (got < 64 && b < 20000) begin
            if (m_valid) begin
                if (got == stall_idx && !stalled) begin
                    m_ready = 0; hold = m_data; stalled = 1;
                    for (int k = 0; k < 10; k++) begin
                        @(negedge clk);
                        if (!m_valid || m_data !== hold || M_AXI_ARVALID) stall_bad++;
                    end
                    m_ready = 1;
                end
                if (m_data !== 32'(base + got + 1)) bad++;
                got++;
            end
            @(negedge clk);
            b++;
        end
    endtask

    task automatic run_block(input string tag, input int base, input int stall_idx,
                             output int got, output int bad, output int stall_bad);
        int sent;
        int b;
        fork
            src(base, sent);
            snk(base, stall_idx, got, bad, stall_bad);
        join
        b = 0;
        while (busy && b < 100) begin @(negedge clk); b++; end
        check({tag, "_sent"}, 64'(sent), 64'd64);
        check({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    function automatic int data_wr_bad(input int base);
        int n;
        n = 0;
        for (int i = 0; i < 64; i++)
            if (wa[i] !== 8'(i) || wd[i] !== 32'(base + i)) n++;
        return n;
    endfunction

    function automatic int count_polls();
        int n;
        n = 0;
        for (int i = 0; i < rd_n; i++) if (ra[i] == 8'h89) n++;
        return n;
    endfunction

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int got, bad, sbad, sent, b;
        s_data = 0; s_valid = 0; m_ready = 1;
        repeat (3) @(negedge clk);
        check("rst_ctrl", 64'({s_ready, m_valid, busy, err, M_AXI_AWVALID, M_AXI_WVALID,
                               M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}), 64'd0);
        check("rst_mdata", 64'(m_data), 64'd0);
        check("rst_addr", 64'({M_AXI_AWADDR, M_AXI_ARADDR}), 64'd0);
        check("rst_wdata", 64'(M_AXI_WDATA), 64'd0);
        rst_n = 1;
        @(negedge clk);

        // 1: basic block, inputs 0..63, done on first poll
        clear_log(); done_after = 1; bad_wr_idx = -1;
        run_block("t1", 0, -1, got, bad, sbad);
        check("t1_words", 64'(got), 64'd64);
        check("t1_mdata_bad", 64'(bad), 64'd0);
        check("t1_wr_count", 64'(wr_n), 64'd67);
        check("t1_data_wr_bad", 64'(data_wr_bad(0)), 64'd0);
        check("t1_start1", {24'd0, wa[64], wd[64]}, {24'd0, 8'h81, 32'd1});
        check("t1_start0", {24'd0, wa[65], wd[65]}, {24'd0, 8'h81, 32'd0});
        check("t1_done0", {24'd0, wa[66], wd[66]}, {24'd0, 8'h89, 32'd0});
        check("t1_rd_count", 64'(rd_n), 64'd65);
        check("t1_err", 64'(err), 64'd0);

        // 2: done on the 5th poll
        clear_log(); done_after = 5;
        run_block("t2", 100, -1, got, bad, sbad);
        check("t2_polls", 64'(count_polls()), 64'd5);
        check("t2_first_fetch", 64'(ra[5]), 64'h40);
        check("t2_gap_ge4", 64'(min_gap >= 4), 64'd1);
        check("t2_mdata_bad", 64'(bad + 64 - got), 64'd0);

        // 3: downstream stall on word 7
        clear_log(); done_after = 2;
        run_block("t3", 200, 7, got, bad, sbad);
        check("t3_stall_bad", 64'(sbad), 64'd0);
        check("t3_words", 64'(got), 64'd64);
        check("t3_mdata_bad", 64'(bad), 64'd0);
        check("t3_viol", 64'(viol), 64'd0);

        // 4: SLVERR on write 12
        clear_log(); done_after = 1; bad_wr_idx = 12;
        run_block("t4", 300, -1, got, bad, sbad);
        bad_wr_idx = -1;
        check("t4_err", 64'(err), 64'd1);
        check("t4_wr_count", 64'(wr_n), 64'd67);
        check("t4_data_wr_bad", 64'(data_wr_bad(300)), 64'd0);
        check("t4_mdata_bad", 64'(bad + 64 - got), 64'd0);

        // 5: reset during write 30 of the next block
        clear_log(); abort = 0;
        fork
            src(400, sent);
            begin
                b = 0;
                while (!(wr_n == 30 && M_AXI_BREADY) && b < 3000) begin @(negedge clk); b++; end
                check("t5_reached_wr30", 64'(b < 3000), 64'd1);
                check("t4_err_sticky", 64'(err), 64'd1);
                rst_n = 0; abort = 1;
                repeat (2) @(negedge clk);
                check("t5_rst_ctrl", 64'({s_ready, m_valid, busy, err, M_AXI_AWVALID, M_AXI_WVALID,
                                          M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}), 64'd0);
                check("t5_rst_addr", 64'({M_AXI_AWADDR, M_AXI_ARADDR}), 64'd0);
                check("t5_rst_data", {M_AXI_WDATA, m_data}, 64'd0);
                rst_n = 1;
            end
        join
        abort = 0;
        @(negedge clk);
        clear_log(); done_after = 1;
        run_block("t5", 500, -1, got, bad, sbad);
        check("t5_first_wr", {24'd0, wa[0], wd[0]}, {24'd0, 8'h00, 32'd500});
        check("t5_data_wr_bad", 64'(data_wr_bad(500)), 64'd0);
        check("t5_mdata_bad", 64'(bad + 64 - got), 64'd0);
        check("t5_err", 64'(err), 64'd0);

`ifdef POLL_TIMEOUT_EN
        // 6: done never set, poll timeout after 200 cycles
        clear_log(); done_after = 0;
        run_block("t6", 600, -1, got, bad, sbad);
        check("t6_err", 64'(err), 64'd1);
        check("t6_err_time", 64'((err_cyc - start_cyc) >= 195 && (err_cyc - start_cyc) <= 230), 64'd1);
        check("t6_start0", {24'd0, wa[65], wd[65]}, {24'd0, 8'h81, 32'd0});
        check("t6_words", 64'(got), 64'd64);
`endif

        check("viol_total", 64'(viol), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
